fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Multi-cycle fetch controller for the SEQ Y86-64 core. It owns the program counter and drives it into the combinational fetch stage. It registers the decoded fetch results and hands one instruction at a time to the downstream stage over a valid/ready handshake. It chooses the next PC itself for sequential, call and unconditional-jump flow, waits for an execute-stage redirect on conditional jumps and `ret`, and halts on any non-AOK status.

## Interface
Parameters:
- `RESET_PC`, default 64'h0: PC value loaded on reset.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `pc`  out  64  PC presented to the fetch stage
- `f_icode`, `f_ifun`  in  4 each  fetch-stage decode of the instruction at `pc`
- `f_valC`, `f_valP`  in  64 each  fetch-stage constant and next sequential PC
- `f_stat`  in  4  fetch status: 0 AOK, 1 HLT, 2 ADR, 3 INS
- `d_valid`  out  1  registered instruction available
- `d_ready`  in  1  downstream accepts this cycle
- `d_icode`, `d_ifun`, `d_stat`  out  4 each  registered copies
- `d_valC`, `d_valP`, `d_pc`  out  64 each  registered copies (`d_pc` = PC of the instruction)
- `redirect_valid`  in  1  resolved target available
- `redirect_pc`  in  64  resolved next PC (jXX taken/not taken, `ret` target)
- `halted`  out  1  sequencer stopped
- `instr_count`, `stall_count`  out  32 each  performance counters (see Configuration)

## Operation
- States: FETCH, ISSUE, WAIT_RESOLVE, HALT.
- FETCH: capture all `f_*` inputs and `pc` into the `d_*` registers, then go to ISSUE.
- ISSUE: `d_valid`=1. The `d_*` outputs stay stable until handshake (`d_valid && d_ready`). On handshake:
  - `d_stat`≠0: set `halted`, go to HALT. `pc` is unchanged.
  - `d_icode`=8 (call), or `d_icode`=7 with `d_ifun`=0 (jmp): `pc`←`d_valC`, go to FETCH.
  - `d_icode`=7 with `d_ifun`≠0, or `d_icode`=9 (ret): go to WAIT_RESOLVE. `pc` is unchanged.
  - Otherwise: `pc`←`d_valP`, go to FETCH.
- WAIT_RESOLVE: `d_valid`=0. On `redirect_valid`: `pc`←`redirect_pc`, go to FETCH.
- `redirect_valid` is ignored in every state except WAIT_RESOLVE.
- HALT: `d_valid`=0. The block is inert until reset; all inputs are ignored.
- PC arithmetic is 64-bit with no overflow check. `pc` wraps modulo 2^64 only as the supplied `d_valP`/`d_valC` dictate.

## Timing
- Reset (asynchronous, any state):
  - `pc`=`RESET_PC`, state FETCH.
  - `d_valid`=0, `halted`=0.
  - All `d_*` data outputs = 0.
  - Counters = 0.
- The FETCH state lasts exactly 1 cycle. `d_valid` rises the cycle after FETCH.
- With `d_ready` held high, throughput is 1 instruction per 2 cycles for non-redirecting flow.
- On handshake, the new `pc` is visible on the next edge, together with the state change to FETCH.
- On the WAIT_RESOLVE redirect edge, `pc` updates and the state becomes FETCH; the next issue follows one cycle later.
- `d_valid` never drops without a handshake. Deasserting `d_ready` only holds the ISSUE state.
- Reset deasserted mid-run restarts fetch at `RESET_PC` on the first clock after release.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `instr_count` increments on each handshake, including the handshake that enters HALT.
  - `stall_count` increments on each cycle in ISSUE with `d_ready`=0, and on each cycle in WAIT_RESOLVE.
  - Both counters wrap at 2^32.
  - Both counters freeze in HALT.
- `FETCH_PERF_CNT_EN` undefined: both outputs are tied to 0 and no counter registers exist.

## Test plan
- Reset with `RESET_PC`=64'h100, then release: `pc`=64'h100 and `d_valid`=0 in the first cycle; `d_valid`=1 with `d_pc`=64'h100 in the second cycle.
- Sequential flow, `d_ready`=1: icode 6 with `f_valP`=64'h102 → next `pc`=64'h102; each instruction is issued 2 cycles apart; `instr_count` increments by 1 per instruction.
- Call with `f_valC`=64'h400 → `pc`=64'h400 one cycle after handshake; `jmp` (7/0) behaves identically.
- Conditional jump (7/3), then `redirect_valid` pulsed 3 cycles later with 64'h250:
  - `d_valid`=0 while waiting.
  - `pc`=64'h250 after the redirect edge.
  - `stall_count` increases by 3.
  - A `redirect_valid` pulse in ISSUE or FETCH is ignored.
- `d_ready` held low for 4 cycles in ISSUE: all `d_*` outputs are stable and `stall_count` increases by 4; handshake proceeds normally on `d_ready`=1.
- `f_stat`=3 (INS) or 1 (HLT) → `halted`=1 after handshake; `pc` is frozen; later `redirect_valid` has no effect; asserting `rst_n`=0 mid-HALT restores all reset values immediately.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller for the SEQ Y86-64 core: owns the PC and issues one instruction per handshake.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] pc,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [3:0]  f_stat,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [3:0]  d_icode,
  output logic [3:0]  d_ifun,
  output logic [3:0]  d_stat,
  output logic [63:0] d_valC,
  output logic [63:0] d_valP,
  output logic [63:0] d_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        halted,
  output logic [31:0] instr_count,
  output logic [31:0] stall_count
);

  localparam logic [1:0] FETCH        = 2'd0;
  localparam logic [1:0] ISSUE        = 2'd1;
  localparam logic [1:0] WAIT_RESOLVE = 2'd2;
  localparam logic [1:0] HALT         = 2'd3;

  localparam logic [3:0] ICODE_JXX  = 4'h7;
  localparam logic [3:0] ICODE_CALL = 4'h8;
  localparam logic [3:0] ICODE_RET  = 4'h9;

  logic [1:0] state;
  logic       handshake;

  assign d_valid   = (state == ISSUE);
  assign halted    = (state == HALT);
  assign handshake = d_valid && d_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      d_icode <= '0;
      d_ifun  <= '0;
      d_stat  <= '0;
      d_valC  <= '0;
      d_valP  <= '0;
      d_pc    <= '0;
    end else begin
      case (state)
        FETCH: begin
          d_icode <= f_icode;
          d_ifun  <= f_ifun;
          d_stat  <= f_stat;
          d_valC  <= f_valC;
          d_valP  <= f_valP;
          d_pc    <= pc;
          state   <= ISSUE;
        end
        ISSUE: begin
          if (d_ready) begin
            // Status outranks control flow: a faulting instruction never redirects the PC.
            if (d_stat != 4'h0) begin
              state <= HALT;
            end else if (d_icode == ICODE_CALL ||
                         (d_icode == ICODE_JXX && d_ifun == 4'h0)) begin
              pc    <= d_valC;
              state <= FETCH;
            end else if (d_icode == ICODE_JXX || d_icode == ICODE_RET) begin
              state <= WAIT_RESOLVE;
            end else begin
              pc    <= d_valP;
              state <= FETCH;
            end
          end
        end
        WAIT_RESOLVE: begin
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= FETCH;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] instr_cnt;
  logic [31:0] stall_cnt;

  // Counters stop on their own in HALT: no handshake and no stall cycles occur there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (handshake)
        instr_cnt <= instr_cnt + 32'd1;
      if ((state == ISSUE && !d_ready) || state == WAIT_RESOLVE)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign instr_count = instr_cnt;
  assign stall_count = stall_cnt;
`else
  assign instr_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: walks sequential, call, jmp, conditional, stall and halt flows.
module tb_fetch_sequencer;

  localparam logic [63:0] RPC = 64'h100;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pc;
  logic [3:0]  f_icode, f_ifun, f_stat;
  logic [63:0] f_valC, f_valP;
  logic        d_valid, d_ready;
  logic [3:0]  d_icode, d_ifun, d_stat;
  logic [63:0] d_valC, d_valP, d_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halted;
  logic [31:0] instr_count, stall_count;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_sequencer #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .f_icode(f_icode), .f_ifun(f_ifun), .f_valC(f_valC), .f_valP(f_valP), .f_stat(f_stat),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_icode(d_icode), .d_ifun(d_ifun), .d_stat(d_stat),
    .d_valC(d_valC), .d_valP(d_valP), .d_pc(d_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .instr_count(instr_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_f(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc,
                       input logic [63:0] vp, input logic [3:0] st);
    f_icode = ic; f_ifun = fn; f_valC = vc; f_valP = vp; f_stat = st;
  endtask

  function automatic logic [63:0] cnt(input int v);
    return PERF ? 64'(v) : 64'd0;
  endfunction

  initial begin
    rst_n = 1'b0; d_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    set_f(4'h6, 4'h0, 64'h0, 64'h102, 4'h0);
    tick(); tick();
    chk("rst_pc", pc, RPC);
    chk("rst_valid", d_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_d_pc", d_pc, 0);
    chk("rst_d_icode", d_icode, 0);
    chk("rst_instr", instr_count, 0);
    chk("rst_stall", stall_count, 0);

    // first cycle after release is FETCH
    rst_n = 1'b1;
    chk("fetch_pc", pc, 64'h100);
    chk("fetch_valid", d_valid, 0);
    tick();
    chk("issue0_valid", d_valid, 1);
    chk("issue0_d_pc", d_pc, 64'h100);
    chk("issue0_icode", d_icode, 4'h6);
    chk("issue0_valP", d_valP, 64'h102);
    tick();
    chk("seq_pc", pc, 64'h102);
    chk("seq_valid_low", d_valid, 0);
    chk("seq_instr", instr_count, cnt(1));

    // call
    set_f(4'h8, 4'h0, 64'h400, 64'h10b, 4'h0);
    tick();
    chk("call_valid", d_valid, 1);
    chk("call_d_pc", d_pc, 64'h102);
    redirect_valid = 1'b1; redirect_pc = 64'hdead;
    tick();
    chk("call_pc", pc, 64'h400);
    chk("call_instr", instr_count, cnt(2));

    // jmp, with a stray redirect held through ISSUE and FETCH
    set_f(4'h7, 4'h0, 64'h500, 64'h409, 4'h0);
    tick();
    chk("jmp_valid", d_valid, 1);
    chk("jmp_d_pc", d_pc, 64'h400);
    chk("stray_redirect_pc", pc, 64'h400);
    redirect_valid = 1'b0;
    tick();
    chk("jmp_pc", pc, 64'h500);

    // conditional jump waits three cycles for resolution
    set_f(4'h7, 4'h3, 64'h300, 64'h509, 4'h0);
    tick();
    chk("jxx_d_pc", d_pc, 64'h500);
    tick();
    chk("jxx_wait_valid", d_valid, 0);
    chk("jxx_wait_pc", pc, 64'h500);
    chk("jxx_instr", instr_count, cnt(4));
    tick();
    chk("jxx_wait2_valid", d_valid, 0);
    tick();
    chk("jxx_wait3_valid", d_valid, 0);
    redirect_valid = 1'b1; redirect_pc = 64'h250;
    tick();
    chk("redirect_pc", pc, 64'h250);
    chk("redirect_valid_low", d_valid, 0);
    chk("redirect_stall", stall_count, cnt(3));
    redirect_valid = 1'b0;

    // downstream back-pressure for four cycles
    set_f(4'h2, 4'h0, 64'h0, 64'h252, 4'h0);
    tick();
    chk("bp_issue_valid", d_valid, 1);
    d_ready = 1'b0;
    set_f(4'h5, 4'h1, 64'h77, 64'h88, 4'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_valid", d_valid, 1);
      chk("bp_hold_d_pc", d_pc, 64'h250);
      chk("bp_hold_icode", d_icode, 4'h2);
      chk("bp_hold_valP", d_valP, 64'h252);
    end
    chk("bp_stall", stall_count, cnt(7));
    d_ready = 1'b1;
    tick();
    chk("bp_release_pc", pc, 64'h252);
    chk("bp_instr", instr_count, cnt(5));

    // INS status on a ret: halt wins over waiting for resolution
    set_f(4'h9, 4'h0, 64'h0, 64'h253, 4'h3);
    tick();
    chk("ins_d_stat", d_stat, 4'h3);
    tick();
    chk("ins_halted", halted, 1);
    chk("ins_pc", pc, 64'h252);
    chk("ins_valid", d_valid, 0);
    chk("ins_instr", instr_count, cnt(6));
    redirect_valid = 1'b1; redirect_pc = 64'hdead;
    set_f(4'h6, 4'h0, 64'h0, 64'h999, 4'h0);
    tick(); tick(); tick();
    chk("halt_pc_frozen", pc, 64'h252);
    chk("halt_still", halted, 1);
    chk("halt_instr_frozen", instr_count, cnt(6));
    chk("halt_stall_frozen", stall_count, cnt(7));

    // asynchronous reset mid-HALT
    #2 rst_n = 1'b0;
    #1;
    chk("areset_pc", pc, RPC);
    chk("areset_halted", halted, 0);
    chk("areset_valid", d_valid, 0);
    chk("areset_d_pc", d_pc, 0);
    chk("areset_d_stat", d_stat, 0);
    chk("areset_instr", instr_count, 0);
    chk("areset_stall", stall_count, 0);
    redirect_valid = 1'b0;
    set_f(4'h0, 4'h0, 64'h0, 64'h101, 4'h1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart_valid", d_valid, 1);
    chk("restart_d_pc", d_pc, 64'h100);
    chk("hlt_d_stat", d_stat, 4'h1);
    tick();
    chk("hlt_halted", halted, 1);
    chk("hlt_pc", pc, 64'h100);
    chk("hlt_instr", instr_count, cnt(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
